// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES slices with a register after each.
// Define PIPE_ADD_SUB_SATURATE_EN to add a per-beat `sat` input that clamps signed overflow to the signed limit.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
`ifdef PIPE_ADD_SUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage k keeps only the operand slices still to be added (UW bits)
  // and the result slices already produced (DW bits).
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UW = WIDTH - k * SW;
    localparam int DW = (k + 1) * SW;

    logic [UW-1:0] a_in;
    logic [UW-1:0] b_in;
    logic          c_in;
    logic          v_in;
`ifdef PIPE_ADD_SUB_SATURATE_EN
    logic          sat_in;
`endif
    logic [SW:0]   sum;
    logic [DW-1:0] r_nx;

    if (k == 0) begin : g_head
      assign a_in = A;
      assign b_in = B ^ {WIDTH{sub}};
      assign c_in = sub;
      assign v_in = in_valid;
      assign r_nx = sum[SW-1:0];
`ifdef PIPE_ADD_SUB_SATURATE_EN
      assign sat_in = sat;
`endif
    end else begin : g_body
      assign a_in = g_st[k-1].g_skew.a_q;
      assign b_in = g_st[k-1].g_skew.b_q;
      assign c_in = g_st[k-1].g_skew.c_q;
      assign v_in = g_st[k-1].g_skew.v_q;
      assign r_nx = {sum[SW-1:0], g_st[k-1].g_skew.r_q};
`ifdef PIPE_ADD_SUB_SATURATE_EN
      assign sat_in = g_st[k-1].g_skew.sat_q;
`endif
    end

    assign sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_skew
      logic [UW-SW-1:0] a_q;
      logic [UW-SW-1:0] b_q;
      logic [DW-1:0]    r_q;
      logic             c_q;
      logic             v_q;
`ifdef PIPE_ADD_SUB_SATURATE_EN
      logic             sat_q;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
`ifdef PIPE_ADD_SUB_SATURATE_EN
          sat_q <= 1'b0;
`endif
        end else if (advance) begin
          a_q <= a_in[UW-1:SW];
          b_q <= b_in[UW-1:SW];
          r_q <= r_nx;
          c_q <= sum[SW];
          v_q <= v_in;
`ifdef PIPE_ADD_SUB_SATURATE_EN
          sat_q <= sat_in;
`endif
        end
      end
    end else begin : g_tail
      logic             ovf_nx;
      logic [WIDTH-1:0] c_nx;

      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      assign ovf_nx = sum[SW] ^ (sum[SW-1] ^ a_in[SW-1] ^ b_in[SW-1]);
`ifdef PIPE_ADD_SUB_SATURATE_EN
      // On overflow both effective operand signs agree, so A's sign picks the limit.
      assign c_nx = (sat_in && ovf_nx) ? {a_in[SW-1], {(WIDTH-1){~a_in[SW-1]}}} : r_nx;
`else
      assign c_nx = r_nx;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          C         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= v_in;
          C         <= c_nx;
          cout      <= sum[SW];
          ovf       <= ovf_nx;
          zero      <= ~|c_nx;
        end
      end
    end
  end

endmodule
